// File: rtl/fxdiv_pkg.sv
// fxdiv_seq shared types: FSM state enum and counter-width helper.
// Imported by fxdiv_seq and fxdiv_step.
package fxdiv_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    ITER,
    FIX,
    DONE
  } state_e;

  function automatic int cnt_w(input int qw);
    return (qw > 1) ? $clog2(qw) : 1;
  endfunction

  localparam int DEF_QW = 24;
  localparam int DEF_CW = cnt_w(DEF_QW);

endpackage

// File: rtl/fxdiv_step.sv
// fxdiv_step: one combinational restoring-division step.
// Ports: i_rem (partial remainder), i_bit (incoming bit), i_div (divisor),
//        o_rem (next remainder), o_q (quotient bit).
module fxdiv_step
  import fxdiv_pkg::*;
#(
  parameter int VW = 8
) (
  input  logic [VW-1:0] i_rem,
  input  logic          i_bit,
  input  logic [VW-1:0] i_div,
  output logic [VW-1:0] o_rem,
  output logic          o_q
);

  logic [VW:0] w_sh;
  logic        w_ge;

  assign w_sh = {i_rem, i_bit};
  assign w_ge = (w_sh >= {1'b0, i_div});

  // A successful subtract always lands below the divisor,
  // so the low VW bits of the difference are exact.
  assign o_rem = w_ge ? (w_sh[VW-1:0] - i_div) : w_sh[VW-1:0];
  assign o_q   = w_ge;

endmodule

// File: rtl/fxdiv_seq.sv
// fxdiv_seq: sequential radix-2 fixed-point divider, (Dividend<<FRAC)/Divisor.
// Ports: Clk, Reset (sync, active-low), Start, Signed_mode, Dividend, Divisor
//        in; Busy, Ack, Quotient, Remainder, Div_by_zero out.
// Optional macro FXDIV_ROUND_EN: round half away from zero instead of truncate.
module fxdiv_seq
  import fxdiv_pkg::*;
#(
  parameter int DW   = 16,
  parameter int VW   = 8,
  parameter int FRAC = 8,
  parameter int QW   = DW + FRAC
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Start,
  input  logic          Signed_mode,
  input  logic [DW-1:0] Dividend,
  input  logic [VW-1:0] Divisor,
  output logic          Busy,
  output logic          Ack,
  output logic [QW-1:0] Quotient,
  output logic [VW-1:0] Remainder,
  output logic          Div_by_zero
);

  localparam int CW = cnt_w(QW);

  state_e        r_state;
  state_e        w_nxt;
  logic [DW-1:0] r_dvd;
  logic [VW-1:0] r_dvs;
  logic          r_neg;
  logic [QW-1:0] r_sr;
  logic [VW-1:0] r_rem;
  logic [CW-1:0] r_cnt;
  logic [QW-1:0] r_quot;
  logic [VW-1:0] r_remo;
  logic          r_dbz;

  logic [DW-1:0] w_mag;
  logic [VW-1:0] w_rem_nxt;
  logic          w_qbit;
  logic          w_rnd;
  logic [QW-1:0] w_qmag;
  logic [QW-1:0] w_qfix;

  fxdiv_step #(
    .VW(VW)
  ) u_step (
    .i_rem(r_rem),
    .i_bit(r_sr[QW-1]),
    .i_div(r_dvs),
    .o_rem(w_rem_nxt),
    .o_q  (w_qbit)
  );

  // -(-2^(DW-1)) wraps back to 2^(DW-1), which is the correct magnitude.
  assign w_mag = r_neg ? DW'(-r_dvd) : r_dvd;

`ifdef FXDIV_ROUND_EN
  assign w_rnd = ({r_rem, 1'b0} >= {1'b0, r_dvs});
`else
  assign w_rnd = 1'b0;
`endif

  assign w_qmag = r_sr + QW'(w_rnd);
  assign w_qfix = r_neg ? QW'(-w_qmag) : w_qmag;

  always_ff @(posedge Clk) begin
    if (!Reset) r_state <= IDLE;
    else        r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    Busy  = 1'b0;
    Ack   = 1'b0;
    unique case (r_state)
      IDLE: if (Start) w_nxt = PREP;
      PREP: begin
        Busy  = 1'b1;
        w_nxt = ITER;
      end
      ITER: begin
        Busy = 1'b1;
        if (r_cnt == '0) w_nxt = FIX;
      end
      FIX: begin
        Busy  = 1'b1;
        w_nxt = DONE;
      end
      DONE: begin
        Ack   = 1'b1;
        w_nxt = IDLE;
      end
      default: w_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      r_dvd  <= '0;
      r_dvs  <= '0;
      r_neg  <= 1'b0;
      r_sr   <= '0;
      r_rem  <= '0;
      r_cnt  <= '0;
      r_quot <= '0;
      r_remo <= '0;
      r_dbz  <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: if (Start) begin
          r_dvd <= Dividend;
          r_dvs <= Divisor;
          r_neg <= Signed_mode & Dividend[DW-1];
        end
        PREP: begin
          r_rem <= '0;
          r_sr  <= QW'(w_mag) << FRAC;
          r_cnt <= CW'(QW - 1);
        end
        ITER: begin
          r_rem <= w_rem_nxt;
          r_sr  <= {r_sr[QW-2:0], w_qbit};
          r_cnt <= r_cnt - 1'b1;
        end
        FIX: begin
          if (r_dvs == '0) begin
            r_quot <= '1;
            r_remo <= '0;
            r_dbz  <= 1'b1;
          end else begin
            r_quot <= w_qfix;
            r_remo <= r_rem;
            r_dbz  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign Quotient    = r_quot;
  assign Remainder   = r_remo;
  assign Div_by_zero = r_dbz;

endmodule

// File: tb/tb_fxdiv_seq.sv
// tb_fxdiv_seq: table vectors, random ops vs arithmetic model,
// and hand sequences for mid-operation Start and Reset.
module tb_fxdiv_seq;

  localparam int DW   = 16;
  localparam int VW   = 8;
  localparam int FRAC = 8;
  localparam int QW   = DW + FRAC;
  localparam int LAT  = QW + 2;

  logic          Clk = 1'b0;
  logic          Reset = 1'b0;
  logic          Start = 1'b0;
  logic          Signed_mode = 1'b0;
  logic [DW-1:0] Dividend = '0;
  logic [VW-1:0] Divisor = '0;
  logic          Busy;
  logic          Ack;
  logic [QW-1:0] Quotient;
  logic [VW-1:0] Remainder;
  logic          Div_by_zero;

  int checks = 0;
  int errors = 0;

  fxdiv_seq dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Start      (Start),
    .Signed_mode(Signed_mode),
    .Dividend   (Dividend),
    .Divisor    (Divisor),
    .Busy       (Busy),
    .Ack        (Ack),
    .Quotient   (Quotient),
    .Remainder  (Remainder),
    .Div_by_zero(Div_by_zero)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    bit            sm;
    logic [DW-1:0] d;
    logic [VW-1:0] v;
    logic [QW-1:0] q;
    logic [VW-1:0] r;
    bit            z;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void model(input bit sm, input logic [DW-1:0] d,
                                input logic [VW-1:0] v,
                                output logic [QW-1:0] q,
                                output logic [VW-1:0] r,
                                output logic z);
    longint val, mag, n, qq, rr, dv;
    val = sm ? longint'($signed(d)) : longint'(d);
    mag = (val < 0) ? -val : val;
    dv  = longint'(v);
    if (dv == 0) begin
      q = '1;
      r = '0;
      z = 1'b1;
      return;
    end
    n  = mag * (longint'(1) << FRAC);
    qq = n / dv;
    rr = n % dv;
`ifdef FXDIV_ROUND_EN
    if (2 * rr >= dv) qq = qq + 1;
`endif
    if (val < 0) qq = -qq;
    q = qq[QW-1:0];
    r = rr[VW-1:0];
    z = 1'b0;
  endfunction

  task automatic launch(input bit sm, input logic [DW-1:0] d,
                        input logic [VW-1:0] v);
    @(negedge Clk);
    Signed_mode = sm;
    Dividend    = d;
    Divisor     = v;
    Start       = 1'b1;
    @(posedge Clk);
    #1 Start = 1'b0;
  endtask

  task automatic wait_ack(output int lat);
    lat = 0;
    while (lat < 100) begin
      @(posedge Clk);
      lat++;
      #1;
      if (Ack) break;
    end
  endtask

  task automatic run_chk(input string name, input bit sm,
                         input logic [DW-1:0] d, input logic [VW-1:0] v,
                         input logic [QW-1:0] eq, input logic [VW-1:0] er,
                         input bit ez);
    int lat;
    launch(sm, d, v);
    chk({name, " busy"}, 64'(Busy), 64'(1));
    wait_ack(lat);
    chk({name, " latency"}, 64'(lat), 64'(LAT));
    chk({name, " busy@ack"}, 64'(Busy), 64'(0));
    chk({name, " quot"}, 64'(Quotient), 64'(eq));
    chk({name, " rem"}, 64'(Remainder), 64'(er));
    chk({name, " dbz"}, 64'(Div_by_zero), 64'(ez));
    @(posedge Clk);
    #1 chk({name, " ack pulse"}, 64'(Ack), 64'(0));
  endtask

  initial begin
    logic [QW-1:0] mq;
    logic [VW-1:0] mr;
    logic          mz;
    int            acks;

    tbl[0] = '{0, 16'h3200, 8'd25, 24'h020000, 8'd0, 0};
    tbl[1] = '{1, 16'hCE00, 8'd25, 24'hFE0000, 8'd0, 0};
`ifdef FXDIV_ROUND_EN
    tbl[2] = '{0, 16'h0002, 8'd3, 24'h0000AB, 8'd2, 0};
`else
    tbl[2] = '{0, 16'h0002, 8'd3, 24'h0000AA, 8'd2, 0};
`endif
    tbl[3] = '{0, 16'h0001, 8'd3, 24'h000055, 8'd1, 0};
    tbl[4] = '{0, 16'h1234, 8'd0, 24'hFFFFFF, 8'd0, 1};
    tbl[5] = '{1, 16'h8000, 8'd1, 24'h800000, 8'd0, 0};
    tbl[6] = '{0, 16'hFFFF, 8'd255, 24'h010100, 8'd0, 0};
    tbl[7] = '{1, 16'hFFFF, 8'd3, 24'hFFFFAB, 8'd1, 0};
    tbl[8] = '{0, 16'hFFFF, 8'd1, 24'hFFFF00, 8'd0, 0};

    repeat (2) @(posedge Clk);
    #1;
    chk("rst busy", 64'(Busy), 64'(0));
    chk("rst ack", 64'(Ack), 64'(0));
    chk("rst quot", 64'(Quotient), 64'(0));
    chk("rst rem", 64'(Remainder), 64'(0));
    chk("rst dbz", 64'(Div_by_zero), 64'(0));
    @(negedge Clk);
    Reset = 1'b1;

    for (int i = 0; i < 9; i++) begin
      run_chk($sformatf("vec%0d", i), tbl[i].sm, tbl[i].d, tbl[i].v,
              tbl[i].q, tbl[i].r, tbl[i].z);
    end

    launch(0, 16'h2D00, 8'd9);
    repeat (5) @(posedge Clk);
    @(negedge Clk);
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    acks = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge Clk);
      #1 if (Ack) acks++;
    end
    chk("midstart acks", 64'(acks), 64'(1));
    chk("midstart quot", 64'(Quotient), 64'(24'h050000));
    chk("midstart rem", 64'(Remainder), 64'(0));

    launch(0, 16'h1000, 8'd7);
    repeat (8) @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
    @(posedge Clk);
    #1;
    chk("midrst busy", 64'(Busy), 64'(0));
    chk("midrst ack", 64'(Ack), 64'(0));
    chk("midrst quot", 64'(Quotient), 64'(0));
    chk("midrst rem", 64'(Remainder), 64'(0));
    chk("midrst dbz", 64'(Div_by_zero), 64'(0));
    @(negedge Clk);
    Reset = 1'b1;
    acks = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge Clk);
      #1 if (Ack) acks++;
    end
    chk("midrst no ack", 64'(acks), 64'(0));
    model(1, 16'hCE00, 8'd25, mq, mr, mz);
    run_chk("after rst", 1, 16'hCE00, 8'd25, mq, mr, mz);

    for (int i = 0; i < 150; i++) begin
      bit            sm;
      logic [DW-1:0] d;
      logic [VW-1:0] v;
      sm = 1'($urandom_range(0, 1));
      d  = DW'($urandom);
      v  = ($urandom_range(0, 15) == 0) ? '0 : VW'($urandom);
      model(sm, d, v, mq, mr, mz);
      run_chk($sformatf("rnd%0d", i), sm, d, v, mq, mr, mz);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fxdiv_seq.md
Name: fxdiv_seq

Overview:
- Parametrised sequential fixed-point divider for the CPU datapath: computes (Dividend << FRAC) / Divisor, truncated toward zero.
- Signed or unsigned dividend is selectable per operation; divisor is always unsigned.
- Generalises the Q-format divide the CPU programs currently do in software loops (Q8.8 averaging, 24-bit quotients) into a Start/Ack coprocessor with configurable widths and fraction bits.
- Radix-2 restoring algorithm, one quotient bit per cycle.

Parameters:
- DW, 16, dividend width in bits.
- VW, 8, divisor width in bits (unsigned).
- FRAC, 8, fraction bits appended to the dividend before dividing.
- QW, DW+FRAC, quotient width (derived; do not override).

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  synchronous, active-low reset.
- Start  in  1  launch request; sampled only in IDLE.
- Signed_mode  in  1  1 = Dividend is two's complement; latched with Start.
- Dividend  in  DW  dividend; latched with Start.
- Divisor  in  VW  unsigned divisor; latched with Start.
- Busy  out  1  high from the cycle after Start is accepted until Ack.
- Ack  out  1  one-cycle completion pulse.
- Quotient  out  QW  result, two's complement in signed mode.
- Remainder  out  VW  magnitude of the remainder (not sign-adjusted).
- Div_by_zero  out  1  set when Divisor was 0; valid with Ack.

Behaviour:
- Reset (Reset==0 at a rising edge): state IDLE; Busy, Ack, Quotient, Remainder and Div_by_zero all 0. Reset takes effect at any state, including mid-operation; the operation in flight is discarded and no Ack is issued.
- FSM states and transitions:
  - IDLE: on Start==1, latch the operands, go to PREP.
  - PREP: magnitude = |Dividend| in signed mode, else Dividend. Load the partial remainder with 0 and the shift register with magnitude<<FRAC. Counter = QW-1. Go to ITER.
  - ITER: shift the remainder left by 1 and bring in the register MSB. If remainder >= Divisor, subtract and shift in quotient bit 1, else 0. Decrement the counter. After QW iterations go to FIX.
  - FIX: negate the quotient if Signed_mode and the dividend is negative. Register Quotient, Remainder and Div_by_zero. Go to DONE.
  - DONE: Ack=1, Busy=0. Go to IDLE.
- Latency: Ack is high in the cycle after the (QW+2)th rising edge following the edge that sampled Start. The cycle count is fixed and independent of the operand values, including divide-by-zero.
- Start is ignored in every state except IDLE; Start held high re-launches only after DONE→IDLE.
- Quotient, Remainder and Div_by_zero hold their values until the next FIX or reset.
- Arithmetic rules:
  - The intermediate remainder is VW+1 bits wide, so there is no overflow.
  - The magnitude of -2^(DW-1) fits in DW unsigned bits. Its negated result is -2^(QW-1), which is representable, so there is no signed overflow.
- Divisor==0: the iterations still run. In FIX, Quotient = all ones, Remainder = 0, Div_by_zero = 1.

Optional Feature:
- Macro: FXDIV_ROUND_EN.
- Defined: FIX rounds the magnitude half away from zero: if 2*remainder >= Divisor, add 1 before sign fix. Remainder still reports the pre-round value. Latency is unchanged because the rounding is folded into FIX. The increment cannot overflow: a nonzero remainder implies Divisor >= 2.
- Undefined: pure truncation toward zero.

Decomposition:
- Package fxdiv_pkg: the state enum (IDLE, PREP, ITER, FIX, DONE) and a localparam helper for the counter width $clog2(QW).
- Sub-module fxdiv_step: combinational single restoring step. Inputs are remainder, incoming bit and divisor; outputs are next remainder and quotient bit. It is instantiated once inside ITER.

Test Plan:
- Unsigned, Dividend=0x3200 (12800), Divisor=25 -> Quotient=0x020000, Remainder=0, Ack exactly 26 edges after Start.
- Signed, Dividend=0xCE00 (-12800), Divisor=25 -> Quotient=0xFE0000, Div_by_zero=0.
- Dividend=0x0002, Divisor=3 -> Quotient=0x0000AA, Remainder=2. With FXDIV_ROUND_EN -> 0x0000AB. Dividend=0x0001, Divisor=3 -> 0x000055 in both builds.
- Divisor=0, Dividend=0x1234 -> Quotient=0xFFFFFF, Remainder=0, Div_by_zero=1, same latency.
- Q8.8 sum 0x2D00 / 9 (average of 1..9) -> Quotient=0x050000. A second Start pulsed mid-ITER is ignored, and exactly one Ack results.
- Reset driven low during ITER -> next cycle all outputs 0, no Ack. A new Start then completes normally with a correct result.
